// File: rtl/ctl_reg_sequencer.sv
// rtl/ctl_reg_sequencer.sv - polls controller BRAM CTL_FLAG, bursts changed register groups, writes FPGA_STATE back
// Optional CTL_SEQ_FLAG_ACK_EN: write the acknowledged group bit back to CTL_FLAG after each strobe.
module ctl_reg_sequencer #(
  parameter int POLL_INTERVAL = 64,
  parameter int RD_LATENCY    = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        bram_en_o,
  output logic        bram_we_o,
  output logic [7:0]  bram_addr_o,
  output logic [15:0] bram_din_o,
  input  logic [15:0] bram_dout_i,
  input  logic [15:0] fpga_state_i,
  output logic        reg_valid_o,
  output logic [7:0]  reg_addr_o,
  output logic [15:0] reg_data_o,
  output logic        update_valid_o,
  output logic [2:0]  update_group_o,
  output logic        force_fan_o,
  output logic        busy_o
);

  localparam logic [7:0] ADDR_CTL_FLAG   = 8'h00;
  localparam logic [7:0] ADDR_FPGA_STATE = 8'h01;
  localparam int CW = $clog2(POLL_INTERVAL + RD_LATENCY + 1) + 1;

  typedef enum logic [2:0] {
    S_WAIT, S_RD_FLAG, S_SCAN, S_BURST, S_STROBE, S_ACK, S_WR_STATE
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] flag_prev_q, flag_prev_d;
  logic [5:0]  pending_q, pending_d;
  logic [2:0]  grp_q, grp_d, low_grp;
  logic [7:0]  addr_q, addr_d;
  logic        done_q, done_d;
  logic        fan_q, fan_d;
  logic        issue;
  logic [RD_LATENCY-1:0]       pv_q;
  logic [RD_LATENCY-1:0][7:0]  pa_q;
`ifdef CTL_SEQ_FLAG_ACK_EN
  logic [15:0] flag_q, flag_d;
`endif

  function automatic logic [7:0] grp_first(input logic [2:0] g);
    case (g)
      3'd0:    return 8'h20;
      3'd1:    return 8'h50;
      3'd2:    return 8'h40;
      3'd3:    return 8'hE0;
      3'd4:    return 8'hF0;
      default: return 8'h11;
    endcase
  endfunction

  function automatic logic [7:0] grp_last(input logic [2:0] g);
    case (g)
      3'd0:    return 8'h2B;
      3'd1:    return 8'h63;
      3'd2:    return 8'h44;
      3'd3:    return 8'hE1;
      3'd4:    return 8'hF0;
      default: return 8'h14;
    endcase
  endfunction

  // Highest index scanned first so the lowest set bit wins.
  always_comb begin
    low_grp = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (pending_q[i]) low_grp = 3'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    flag_prev_d = flag_prev_q;
    pending_d   = pending_q;
    grp_d       = grp_q;
    addr_d      = addr_q;
    done_d      = done_q;
    fan_d       = fan_q;
`ifdef CTL_SEQ_FLAG_ACK_EN
    flag_d      = flag_q;
`endif
    issue          = 1'b0;
    bram_en_o      = 1'b0;
    bram_we_o      = 1'b0;
    bram_addr_o    = 8'h00;
    bram_din_o     = 16'h0000;
    update_valid_o = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == CW'(POLL_INTERVAL - 1)) begin
          state_d = S_RD_FLAG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RD_FLAG: begin
        if (cnt_q == '0) begin
          bram_en_o   = 1'b1;
          bram_addr_o = ADDR_CTL_FLAG;
        end
        if (cnt_q == CW'(RD_LATENCY)) begin
          fan_d       = bram_dout_i[13];
          pending_d   = bram_dout_i[5:0] & ~flag_prev_q[5:0];
          flag_prev_d = bram_dout_i;
`ifdef CTL_SEQ_FLAG_ACK_EN
          flag_d      = bram_dout_i;
`endif
          cnt_d       = '0;
          state_d     = S_SCAN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SCAN: begin
        if (pending_q != 6'd0) begin
          grp_d   = low_grp;
          addr_d  = grp_first(low_grp);
          done_d  = 1'b0;
          state_d = S_BURST;
        end else begin
          state_d = S_WR_STATE;
        end
      end
      S_BURST: begin
        if (!done_q) begin
          bram_en_o   = 1'b1;
          bram_addr_o = addr_q;
          issue       = 1'b1;
          if (addr_q == grp_last(grp_q)) done_d = 1'b1;
          else                            addr_d = addr_q + 8'd1;
        end
        // Leave once the final word of the group has been delivered.
        if (pv_q[RD_LATENCY-1] && pa_q[RD_LATENCY-1] == grp_last(grp_q)) state_d = S_STROBE;
      end
      S_STROBE: begin
        update_valid_o = 1'b1;
        pending_d      = pending_q & ~(6'b000001 << grp_q);
`ifdef CTL_SEQ_FLAG_ACK_EN
        flag_d  = flag_q & ~(16'h0001 << grp_q);
        state_d = S_ACK;
`else
        state_d = S_SCAN;
`endif
      end
`ifdef CTL_SEQ_FLAG_ACK_EN
      S_ACK: begin
        bram_en_o   = 1'b1;
        bram_we_o   = 1'b1;
        bram_addr_o = ADDR_CTL_FLAG;
        bram_din_o  = flag_q;
        state_d     = S_SCAN;
      end
`endif
      S_WR_STATE: begin
        bram_en_o   = 1'b1;
        bram_we_o   = 1'b1;
        bram_addr_o = ADDR_FPGA_STATE;
        bram_din_o  = fpga_state_i;
        cnt_d       = '0;
        state_d     = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_WAIT;
      cnt_q       <= '0;
      flag_prev_q <= 16'h0000;
      pending_q   <= 6'd0;
      grp_q       <= 3'd0;
      addr_q      <= 8'h00;
      done_q      <= 1'b0;
      fan_q       <= 1'b0;
      pv_q        <= '0;
      pa_q        <= '0;
`ifdef CTL_SEQ_FLAG_ACK_EN
      flag_q      <= 16'h0000;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flag_prev_q <= flag_prev_d;
      pending_q   <= pending_d;
      grp_q       <= grp_d;
      addr_q      <= addr_d;
      done_q      <= done_d;
      fan_q       <= fan_d;
      pv_q[0]     <= issue;
      pa_q[0]     <= bram_addr_o;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
      end
`ifdef CTL_SEQ_FLAG_ACK_EN
      flag_q      <= flag_d;
`endif
    end
  end

  assign reg_valid_o    = pv_q[RD_LATENCY-1];
  assign reg_addr_o     = pv_q[RD_LATENCY-1] ? pa_q[RD_LATENCY-1] : 8'h00;
  assign reg_data_o     = pv_q[RD_LATENCY-1] ? bram_dout_i : 16'h0000;
  assign update_group_o = update_valid_o ? grp_q : 3'd0;
  assign force_fan_o    = fan_q;
  assign busy_o         = (state_q != S_WAIT);

endmodule

// File: tb/tb_ctl_reg_sequencer.sv
// tb/tb_ctl_reg_sequencer.sv - directed self-checking bench for ctl_reg_sequencer
module tb_ctl_reg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bram_en, bram_we;
  logic [7:0]  bram_addr;
  logic [15:0] bram_din;
  logic [15:0] bram_dout;
  logic [15:0] fpga_state = 16'h0000;
  logic        reg_valid;
  logic [7:0]  reg_addr;
  logic [15:0] reg_data;
  logic        update_valid;
  logic [2:0]  update_group;
  logic        force_fan, busy;

  int total = 0;
  int bad   = 0;

  ctl_reg_sequencer #(.POLL_INTERVAL(16), .RD_LATENCY(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .bram_en_o(bram_en), .bram_we_o(bram_we), .bram_addr_o(bram_addr),
    .bram_din_o(bram_din), .bram_dout_i(bram_dout), .fpga_state_i(fpga_state),
    .reg_valid_o(reg_valid), .reg_addr_o(reg_addr), .reg_data_o(reg_data),
    .update_valid_o(update_valid), .update_group_o(update_group),
    .force_fan_o(force_fan), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // BRAM port B model (2-cycle read latency) plus a CPU-side write port.
  logic [15:0] mem [256];
  logic [15:0] rd0 = 16'h0, rd1 = 16'h0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_addr = 8'h0;
  logic [15:0] cpu_din = 16'h0;
  always @(posedge clk) begin
    if (cpu_wr) mem[cpu_addr] <= cpu_din;
    if (bram_en && bram_we) mem[bram_addr] <= bram_din;
    if (bram_en && !bram_we) rd0 <= mem[bram_addr];
    rd1 <= rd0;
  end
  assign bram_dout = rd1;

  int cyc = 0;
  int wr01_cnt = 0;
  int en_viol = 0;
  logic [7:0]  rq_a[$];
  logic [15:0] rq_d[$];
  int          rq_c[$];
  logic [2:0]  uq_g[$];
  int          uq_c[$];
  logic [7:0]  wq_a[$];
  logic [15:0] wq_d[$];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reg_valid) begin rq_a.push_back(reg_addr); rq_d.push_back(reg_data); rq_c.push_back(cyc); end
    if (update_valid) begin uq_g.push_back(update_group); uq_c.push_back(cyc); end
    if (bram_en && bram_we) begin
      wq_a.push_back(bram_addr); wq_d.push_back(bram_din);
      if (bram_addr == 8'h01) wr01_cnt <= wr01_cnt + 1;
    end
    if (!busy && bram_en) en_viol <= en_viol + 1;
  end

  function automatic logic [15:0] exp_data(input logic [7:0] a);
    if (a >= 8'h20 && a <= 8'h2B) return 16'h1000 + 16'(a - 8'h20);
    return {8'hC0, a};
  endfunction

  task automatic cpu_write(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    cpu_wr = 1'b1; cpu_addr = a; cpu_din = d;
    @(negedge clk);
    cpu_wr = 1'b0;
  endtask

  task automatic wait_polls(input int n);
    int target;
    target = wr01_cnt + n;
    for (int k = 0; k < 3000 && wr01_cnt < target; k++) begin
      @(posedge clk); #2;
    end
    if (wr01_cnt < target) begin
      total++; bad++;
      $display("FAIL poll_timeout: polls=%0d required=%0d", wr01_cnt, target);
    end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int a = 0; a < 256; a++) cpu_write(8'(a), (a < 2) ? 16'h0000 : exp_data(8'(a)));
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b want=0", busy); end
    total++; if (bram_en !== 1'b0) begin bad++; $display("FAIL reset_en: got=%b want=0", bram_en); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (reg_valid !== 1'b0) begin bad++; $display("FAIL reset_regvalid: got=%b want=0", reg_valid); end
    total++; if (update_valid !== 1'b0) begin bad++; $display("FAIL reset_upd: got=%b want=0", update_valid); end
    total++; if (force_fan !== 1'b0) begin bad++; $display("FAIL reset_fan: got=%b want=0", force_fan); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy2: got=%b want=0", busy); end
    wait_polls(1);
  endtask

  task automatic test_mod;
    int s, us, n;
    s = rq_a.size(); us = uq_g.size();
    cpu_write(8'h00, 16'h0001);
    wait_polls(1);
    n = rq_a.size() - s;
    total++; if (n !== 12) begin bad++; $display("FAIL mod_count: got=%0d want=12", n); end
    for (int i = 0; i < 12; i++) begin
      if (s + i < rq_a.size()) begin
        total++;
        if (rq_a[s+i] !== 8'(8'h20 + i) || rq_d[s+i] !== 16'(16'h1000 + i) || rq_c[s+i] !== rq_c[s] + i) begin
          bad++;
          $display("FAIL mod_word%0d: addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                   i, rq_a[s+i], rq_d[s+i], rq_c[s+i], 8'(8'h20 + i), 16'(16'h1000 + i), rq_c[s] + i);
        end
      end
    end
    total++;
    if (uq_g.size() - us !== 1) begin
      bad++; $display("FAIL mod_upd_count: got=%0d want=1", uq_g.size() - us);
    end else if (uq_g[us] !== 3'd0 || (n > 0 && uq_c[us] !== rq_c[rq_c.size()-1] + 1)) begin
      bad++; $display("FAIL mod_upd: group=%0d cyc=%0d want group=0 cyc=%0d", uq_g[us], uq_c[us], rq_c[rq_c.size()-1] + 1);
    end
  endtask

  task automatic test_multi;
    int s, us;
    logic [7:0] ea[$];
    logic [2:0] eg[3];
    eg[0] = 3'd1; eg[1] = 3'd2; eg[2] = 3'd5;
    for (int a = 8'h50; a <= 8'h63; a++) ea.push_back(8'(a));
    for (int a = 8'h40; a <= 8'h44; a++) ea.push_back(8'(a));
    for (int a = 8'h11; a <= 8'h14; a++) ea.push_back(8'(a));
    s = rq_a.size(); us = uq_g.size();
    cpu_write(8'h00, 16'h0026);
    wait_polls(1);
    total++; if (rq_a.size() - s !== 29) begin bad++; $display("FAIL multi_count: got=%0d want=29", rq_a.size() - s); end
    for (int i = 0; i < 29; i++) begin
      if (s + i < rq_a.size()) begin
        total++;
        if (rq_a[s+i] !== ea[i] || rq_d[s+i] !== exp_data(ea[i])) begin
          bad++; $display("FAIL multi_word%0d: addr=%h data=%h want addr=%h data=%h", i, rq_a[s+i], rq_d[s+i], ea[i], exp_data(ea[i]));
        end
      end
    end
    total++; if (uq_g.size() - us !== 3) begin bad++; $display("FAIL multi_upd_count: got=%0d want=3", uq_g.size() - us); end
    for (int i = 0; i < 3; i++) begin
      if (us + i < uq_g.size()) begin
        total++;
        if (uq_g[us+i] !== eg[i]) begin bad++; $display("FAIL multi_group%0d: got=%0d want=%0d", i, uq_g[us+i], eg[i]); end
      end
    end
    total++;
    if (wq_a.size() == 0 || wq_a[wq_a.size()-1] !== 8'h01) begin
      bad++; $display("FAIL multi_wrstate: last write addr=%h want=01", (wq_a.size() > 0) ? wq_a[wq_a.size()-1] : 8'hxx);
    end
  endtask

  task automatic test_hold;
    int s, us;
    cpu_write(8'h00, 16'h0000);
    wait_polls(1);
    s = rq_a.size(); us = uq_g.size();
    cpu_write(8'h00, 16'h0004);
    wait_polls(3);
    total++; if (rq_a.size() - s !== 5) begin bad++; $display("FAIL hold_count: got=%0d want=5", rq_a.size() - s); end
    total++;
    if (uq_g.size() - us !== 1 || uq_g[uq_g.size()-1] !== 3'd2) begin
      bad++; $display("FAIL hold_upd: count=%0d want=1 group=2", uq_g.size() - us);
    end
    cpu_write(8'h00, 16'h0000);
    wait_polls(1);
    s = rq_a.size(); us = uq_g.size();
    cpu_write(8'h00, 16'h0004);
    wait_polls(1);
    total++;
    if (rq_a.size() - s !== 5 || (rq_a.size() > 0 && rq_a[rq_a.size()-1] !== 8'h44)) begin
      bad++; $display("FAIL rearm_count: got=%0d want=5 ending at 44", rq_a.size() - s);
    end
    total++; if (uq_g.size() - us !== 1) begin bad++; $display("FAIL rearm_upd: got=%0d want=1", uq_g.size() - us); end
  endtask

  task automatic test_state_fan;
    int us;
    fpga_state = 16'hA5A5;
    cpu_write(8'h00, 16'h0000);
    wait_polls(1);
    us = uq_g.size();
    cpu_write(8'h00, 16'h2000);
    wait_polls(1);
    total++;
    if (wq_a[wq_a.size()-1] !== 8'h01 || wq_d[wq_d.size()-1] !== 16'hA5A5) begin
      bad++; $display("FAIL state_write: addr=%h data=%h want addr=01 data=a5a5", wq_a[wq_a.size()-1], wq_d[wq_d.size()-1]);
    end
    total++; if (force_fan !== 1'b1) begin bad++; $display("FAIL fan_set: got=%b want=1", force_fan); end
    total++; if (uq_g.size() !== us) begin bad++; $display("FAIL fan_no_upd: got=%0d want=0", uq_g.size() - us); end
    cpu_write(8'h00, 16'h0000);
    wait_polls(1);
    total++; if (force_fan !== 1'b0) begin bad++; $display("FAIL fan_clear: got=%b want=0", force_fan); end
    total++; if (en_viol !== 0) begin bad++; $display("FAIL en_idle: got=%0d want=0", en_viol); end
  endtask

  task automatic test_reset_mid;
    int s, us;
    us = uq_g.size();
    s = rq_a.size();
    cpu_write(8'h00, 16'h0002);
    for (int k = 0; k < 3000 && rq_a.size() < s + 7; k++) begin
      @(posedge clk); #2;
    end
    total++; if (rq_a.size() < s + 7) begin bad++; $display("FAIL midrst_reach: words=%0d want=7", rq_a.size() - s); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({reg_valid, update_valid, bram_en, bram_we, busy, force_fan} !== 6'b0 || reg_addr !== 8'h00 || reg_data !== 16'h0) begin
      bad++; $display("FAIL midrst_outputs: valid=%b upd=%b en=%b we=%b busy=%b addr=%h want all 0",
                      reg_valid, update_valid, bram_en, bram_we, busy, reg_addr);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    s = rq_a.size();
    wait_polls(1);
    total++;
    if (rq_a.size() - s !== 20 || rq_a[s] !== 8'h50 || rq_a[rq_a.size()-1] !== 8'h63) begin
      bad++; $display("FAIL midrst_replay: count=%0d want=20 from 50 to 63", rq_a.size() - s);
    end
    total++;
    if (uq_g.size() - us !== 1 || uq_g[uq_g.size()-1] !== 3'd1) begin
      bad++; $display("FAIL midrst_upd: count=%0d want=1 group=1", uq_g.size() - us);
    end
  endtask

`ifdef CTL_SEQ_FLAG_ACK_EN
  task automatic test_ack;
    int ws;
    logic [15:0] acks[$];
    cpu_write(8'h00, 16'h0000);
    wait_polls(1);
    ws = wq_a.size();
    cpu_write(8'h00, 16'h0003);
    wait_polls(1);
    for (int i = ws; i < wq_a.size(); i++) if (wq_a[i] == 8'h00) acks.push_back(wq_d[i]);
    total++;
    if (acks.size() !== 2 || acks[0] !== 16'h0002 || acks[1] !== 16'h0000) begin
      bad++; $display("FAIL ack_writes: count=%0d want 2 writes 0002 then 0000", acks.size());
    end
  endtask
`endif

  initial begin
    test_reset;
    test_mod;
    test_multi;
    test_hold;
    test_state_fan;
    test_reset_mid;
`ifdef CTL_SEQ_FLAG_ACK_EN
    test_ack;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
